// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory access controller.
//   SZ_*      request size encodings (11 is illegal)
//   state_t   controller FSM states
//   misalign  flags requests that may never reach the RAM
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RDATA,
    WRITE,
    RESP,
    ERR
  } state_t;

  // Misaligned half/word or the illegal size code.
  function automatic logic misalign(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = a[0];
      SZ_W:    misalign = (a != 2'b00);
      default: misalign = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Core-side load/store port of the data-memory controller.
//   req_*  valid/ready request (write flag, size, unsigned, byte address, wdata)
//   rsp_*  one-cycle response pulse with load data and error flag
//   master = core, slave = controller
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for a 32-bit little-endian RAM word.
//   word        RAM word being read
//   addr        byte offset within the word (lane)
//   size/uns    access size and zero-extend flag for loads
//   wdata       right-aligned store data
//   load_data   extracted, sign/zero-extended load result
//   merged_word word with only the addressed lanes replaced by wdata
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);
  logic [4:0]  bsh, hsh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign bsh    = {addr, 3'b000};
  assign hsh    = {addr[1], 4'b0000};
  assign lane_b = word[bsh +: 8];
  assign lane_h = word[hsh +: 16];

  always_comb begin
    load_data   = word;
    merged_word = word;
    case (size)
      SZ_B: begin
        load_data             = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
        merged_word[bsh +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data              = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
        merged_word[hsh +: 16] = wdata[15:0];
      end
      SZ_W:    merged_word = wdata;
      default: load_data   = '0;
    endcase
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: core load/store port -> word-wide RAM.
//   clk, rst     clock, synchronous active-high reset
//   bus          core request/response (slave side)
//   ram_cs/oe/wr RAM strobes; ram_address word address; ram_datain write word
//   ram_dataout  RAM read data, valid the cycle after cs&oe
// Sub-word stores are read-modify-write; misaligned requests go straight to ERR.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  dmem_access_ctrl_if.slave bus,
  output logic              ram_cs,
  output logic              ram_oe,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_datain,
  input  logic [31:0]       ram_dataout
);
  state_t            state_q, state_d;
  logic              write_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  // Holds the load result for RESP, or the word to write in WRITE.
  logic [31:0]       word_q;
  logic [31:0]       load_data, merged_word;
  logic              accept;

  assign accept = (state_q == IDLE) && bus.req_valid;

  dmem_lane_align u_align (
    .word        (ram_dataout),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .uns         (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else if (accept) begin
      write_q <= bus.req_write;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      // Aligned word stores skip the read, so the write word is wdata itself.
      word_q  <= bus.req_write ? bus.req_wdata : '0;
    end else if (state_q == RDATA) begin
      word_q  <= write_q ? merged_word : load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (misalign(bus.req_size, bus.req_addr[1:0]))   state_d = ERR;
        else if (bus.req_write && bus.req_size == SZ_W) state_d = WRITE;
        else                                            state_d = READ;
      end
      READ:    state_d = RDATA;
      RDATA:   state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    ram_cs        = 1'b0;
    ram_oe        = 1'b0;
    ram_wr        = 1'b0;
    ram_address   = addr_q[ADDR_W+1:2];
    ram_datain    = word_q;
    case (state_q)
      IDLE:  bus.req_ready = 1'b1;
      READ:  begin ram_cs = 1'b1; ram_oe = 1'b1; end
      WRITE: begin ram_cs = 1'b1; ram_wr = 1'b1; end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (!write_q) bus.rsp_rdata = word_q;
      end
      ERR: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word RAM.
module tb_dmem_access_ctrl;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              ram_cs, ram_oe, ram_wr;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_datain, ram_dataout;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  int n_err = 0;
  int n_chk = 0;

  // Observations collected per transaction
  int          lat, cs_cnt, rd_cnt, wr_cnt, wr_cyc, rv_cnt;
  logic [31:0] rdata, wr_data;
  logic [31:0] wr_addr;
  logic        err;

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ram_cs      (ram_cs),
    .ram_oe      (ram_oe),
    .ram_wr      (ram_wr),
    .ram_address (ram_address),
    .ram_datain  (ram_datain),
    .ram_dataout (ram_dataout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_address] <= ram_datain;
    if (ram_cs && ram_oe) ram_dataout <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Sample each cycle after the accept edge until the response pulse.
  task automatic wait_rsp();
    lat = -1; cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; wr_cyc = -1;
    rdata = 'x; err = 1'bx; wr_data = 'x; wr_addr = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ram_cs) cs_cnt++;
      if (ram_cs && ram_oe) rd_cnt++;
      if (ram_cs && ram_wr) begin
        wr_cnt++; wr_cyc = c; wr_data = ram_datain; wr_addr = 32'(ram_address);
      end
      if (bus.rsp_valid) begin
        lat = c; rdata = bus.rsp_rdata; err = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic uns,
                      input logic [11:0] addr, input logic [31:0] exp);
    issue(1'b0, sz, uns, addr, 32'h0);
    wait_rsp();
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_data"}, rdata, exp);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [11:0] addr,
                       input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_addr,
                       input logic [31:0] exp_word);
    issue(1'b1, sz, 1'b0, addr, wd);
    wait_rsp();
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'd1);
    chk({tag, "_waddr"}, wr_addr, exp_addr);
    chk({tag, "_wdata"}, wr_data, exp_word);
    chk({tag, "_rdata"}, rdata, 32'h0);
  endtask

  task automatic bad(input string tag, input logic wr, input logic [1:0] sz,
                     input logic [11:0] addr);
    issue(wr, sz, 1'b0, addr, 32'hFFFF_FFFF);
    wait_rsp();
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_cs"}, 32'(cs_cnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rerr", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_strobes", {29'd0, ram_cs, ram_oe, ram_wr}, 32'd0);

    // Word store, then word load back
    store("sw", 2'b10, 12'h010, 32'hDEAD_BEEF, 2, 32'd4, 32'hDEAD_BEEF);
    chk("sw_wrcyc", 32'(wr_cyc), 32'd1);
    chk("sw_noread", 32'(rd_cnt), 32'd0);
    load("lw", 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);

    // Lane extraction from 0x8077F001
    store("sw2", 2'b10, 12'h010, 32'h8077_F001, 2, 32'd4, 32'h8077_F001);
    load("lb13",  2'b00, 1'b0, 12'h013, 32'hFFFF_FF80);
    load("lbu13", 2'b00, 1'b1, 12'h013, 32'h0000_0080);
    load("lb11",  2'b00, 1'b0, 12'h011, 32'hFFFF_FFF0);
    load("lbu10", 2'b00, 1'b1, 12'h010, 32'h0000_0001);
    load("lh12",  2'b01, 1'b0, 12'h012, 32'hFFFF_8077);
    load("lhu10", 2'b01, 1'b1, 12'h010, 32'h0000_F001);
    load("lh10",  2'b01, 1'b0, 12'h010, 32'hFFFF_F001);

    // Sub-word read-modify-write on word 5; upper wdata bits must be ignored
    store("sw3", 2'b10, 12'h014, 32'h1122_3344, 2, 32'd5, 32'h1122_3344);
    store("sb", 2'b00, 12'h015, 32'hFFFF_FFAB, 4, 32'd5, 32'h1122_AB44);
    chk("sb_rdcnt", 32'(rd_cnt), 32'd1);
    chk("sb_wrcyc", 32'(wr_cyc), 32'd3);
    store("sh", 2'b01, 12'h016, 32'h1234_CAFE, 4, 32'd5, 32'hCAFE_AB44);
    load("lw5", 2'b10, 1'b0, 12'h014, 32'hCAFE_AB44);

    // Misaligned / illegal
    bad("lw_mis", 1'b0, 2'b10, 12'h002);
    bad("lh_mis", 1'b0, 2'b01, 12'h001);
    bad("sz11",   1'b0, 2'b11, 12'h010);
    bad("sw_mis", 1'b1, 2'b10, 12'h013);

    // Reset while the RMW is in RDATA
    issue(1'b1, 2'b00, 1'b0, 12'h014, 32'h0000_0055);
    wr_cnt = 0; rv_cnt = 0;
    @(negedge clk);                       // READ
    if (ram_cs && ram_wr) wr_cnt++;
    if (bus.rsp_valid) rv_cnt++;
    @(negedge clk);                       // RDATA
    chk("rmw_rst_rdata_state", {29'd0, ram_cs, ram_oe, ram_wr}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("rmw_rst_ready", {31'd0, bus.req_ready}, 32'd1);
      if (ram_cs && ram_wr) wr_cnt++;
      if (bus.rsp_valid) rv_cnt++;
    end
    chk("rmw_rst_nowr", 32'(wr_cnt), 32'd0);
    chk("rmw_rst_norsp", 32'(rv_cnt), 32'd0);
    load("rmw_rst_word", 2'b10, 1'b0, 12'h014, 32'hCAFE_AB44);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 12'h010;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), {31'd0, bus.req_ready}, 32'd0);
    end
    chk("b2b_rsp1_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("b2b_rsp1_data", bus.rsp_rdata, 32'h8077_F001);
    bus.req_addr = 12'h014;
    @(negedge clk);
    chk("b2b_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_idle_norsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_rsp();
    chk("b2b_rsp2_lat", 32'(lat), 32'd3);
    chk("b2b_rsp2_data", rdata, 32'hCAFE_AB44);
    @(negedge clk);
    chk("end_rdata_zero", bus.rsp_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller between the RISC-V CORE's load/store port and the word-organised data RAM. Accepts one byte/halfword/word load or store at a time over a valid/ready handshake. Converts byte addresses to RAM word addresses and performs lane extraction with sign/zero extension. Implements sub-word stores as read-modify-write, because the RAM writes whole words only. Misaligned accesses are flagged and never reach the RAM.

## Interface
- DATA_W, 32: data width; fixed at 32 (four byte lanes).
- ADDR_W, 10: RAM word-address width; the core byte address is ADDR_W+2 bits.
- CLK  in  1  single clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  core presents a request.
- REQ_READY  out  1  controller can accept; high only in IDLE.
- REQ_WRITE  in  1  1 = store, 0 = load.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  loads: zero-extend when 1, sign-extend when 0.
- REQ_ADDR  in  ADDR_W+2  byte address.
- REQ_WDATA  in  32  store data, right-aligned.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  32  load result; 0 for stores and errors.
- RSP_ERR  out  1  misaligned/illegal request, qualified by RSP_VALID.
- RAM_CS  out  1  RAM chip select.
- RAM_OE  out  1  RAM read enable.
- RAM_WR  out  1  RAM write enable.
- RAM_ADDRESS  out  ADDR_W  word address = latched REQ_ADDR[ADDR_W+1:2].
- RAM_DATAIN  out  32  word written to RAM.
- RAM_DATAOUT  in  32  RAM read data, valid the cycle after CS&OE.

## Operation
- Request accepted on an edge with REQ_VALID & REQ_READY. Address, size, unsigned flag, write flag and wdata are latched; the core may change its inputs afterwards.
- Misaligned conditions:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - size 11.
- FSM states and transitions:
  - IDLE: REQ_READY=1. On accept, go to ERR if misaligned, WRITE for an aligned word store, otherwise READ.
  - READ: CS=1, OE=1, WR=0. Go to RDATA.
  - RDATA: capture RAM_DATAOUT into the word register. Loads go to RESP. Stores build the merged word and go to WRITE.
  - WRITE: CS=1, WR=1, OE=0, RAM_DATAIN = merged word (or wdata for a word store). Go to RESP.
  - RESP: RSP_VALID=1, RSP_ERR=0. Go to IDLE.
  - ERR: RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0, no RAM strobe. Go to IDLE.
- Lanes are little-endian; lane = addr[1:0].
  - Byte: bits [8·lane+7:8·lane].
  - Half: bits [16·addr[1]+15:16·addr[1]].
  - Extension to 32 bits per REQ_UNSIGNED.
  - Word: passed unchanged.
- Merge replaces only the addressed lanes with REQ_WDATA[7:0] or [15:0]; all other lanes keep the RAM value.
- RAM_CS/OE/WR are 0 in IDLE, RDATA, RESP and ERR. RAM_ADDRESS and RAM_DATAIN are don't-care when CS=0.

## Timing
- Reset state: IDLE. REQ_READY=1 the first cycle after reset; RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, RAM_CS/OE/WR=0, internal registers 0.
- Latency from the accept edge (cycle 0) to RSP_VALID:
  - word store: cycle 2;
  - load: cycle 3;
  - sub-word store: cycle 4;
  - error: cycle 1.
- One outstanding request. Next accept earliest in the cycle after RESP/ERR; the minimum issue interval is latency+1.
- RSP_RDATA is valid only while RSP_VALID=1 and is 0 otherwise.
- RST during any state:
  - the next cycle is IDLE;
  - no RAM strobe and no RSP_VALID for the abandoned request;
  - a WRITE in progress on the reset edge is not repeated.
- REQ_VALID outside IDLE is ignored and not queued.

## Structure
- Package dmem_pkg:
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10;
  - FSM state enum (IDLE, READ, RDATA, WRITE, RESP, ERR);
  - misalign function.
- One combinational sub-module, dmem_lane_align:
  - inputs: word, addr[1:0], size, unsigned, wdata;
  - outputs: load_data and merged_word.
- The top holds the FSM and request registers.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x010, then word load from 0x010:
  - store: RAM_WR at cycle 1, RAM_ADDRESS=4;
  - load: RSP_RDATA=0xDEADBEEF at cycle 3.
- RAM word 4 = 0x8077F001:
  - lb @0x013 → 0xFFFFFF80;
  - lbu @0x013 → 0x00000080;
  - lh @0x012 → 0xFFFF8077;
  - lhu @0x010 → 0x0000F001.
- Sub-word stores to a RAM word of 0x11223344:
  - sb 0xAB @0x011: one read, then write 0x1122AB44, RSP at cycle 4;
  - sh 0xCAFE @0x012 on the result: write 0xCAFEAB44.
- Misaligned requests: lw @0x002, lh @0x001, size=11:
  - each gives RSP_VALID with RSP_ERR=1 at cycle 1;
  - RAM_CS stays 0 throughout.
- Reset mid-RMW: sb accepted, RST asserted in RDATA:
  - no RAM_WR;
  - no RSP_VALID;
  - REQ_READY=1 the next cycle;
  - RAM word unchanged.
- Back-to-back: REQ_VALID held high with two loads:
  - second accepted only in the IDLE cycle after the first RSP;
  - REQ_READY=0 from cycle 1 to cycle 3.
